// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: flow-control FSM state encoding, NOP
// instruction encoding and register-address width.
package pipeline_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } flow_state_t;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard comparator: flags when the load in EX writes a register
// that the instruction in ID reads. Register 0 never creates a hazard.
module hazard_detect_unit
    import pipeline_pkg::*;
#(
    parameter int NB_REG_ADDR = REG_ADDR_W
) (
    input  logic                   mem_read,
    input  logic [NB_REG_ADDR-1:0] ex_rt,
    input  logic [NB_REG_ADDR-1:0] id_rs,
    input  logic [NB_REG_ADDR-1:0] id_rt,
    output logic                   load_use
);

    assign load_use = mem_read & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline flow control: load-use stalls, branch flushes, debug single-step
// and halt draining. Define FLOW_CTRL_PERF_CNT_EN to build the stall/flush counters.
module pipeline_flow_ctrl
    import pipeline_pkg::*;
#(
    parameter int NB_REG_ADDR  = REG_ADDR_W,
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_CNT       = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ID_EX_memRead,
    input  logic [NB_REG_ADDR-1:0] i_ID_EX_rt,
    input  logic [NB_REG_ADDR-1:0] i_IF_ID_rs,
    input  logic [NB_REG_ADDR-1:0] i_IF_ID_rt,
    input  logic                   i_branch_taken,
    input  logic                   i_halt,
    input  logic                   i_debug_mode,
    input  logic                   i_step,
    output logic                   o_pipe_en,
    output logic                   o_PCwrite,
    output logic                   o_IF_ID_write,
    output logic                   o_IF_ID_flush,
    output logic                   o_ID_EX_bubble,
    output logic                   o_halted,
    output logic [NB_CNT-1:0]      o_stall_count,
    output logic [NB_CNT-1:0]      o_flush_count
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

    flow_state_t        state, state_next;
    logic [DRAIN_W-1:0] drain_cnt, drain_cnt_next;
    logic               i_step_q;
    logic               step_pulse;
    logic               load_use;

    hazard_detect_unit #(
        .NB_REG_ADDR(NB_REG_ADDR)
    ) u_hazard (
        .mem_read (i_ID_EX_memRead),
        .ex_rt    (i_ID_EX_rt),
        .id_rs    (i_IF_ID_rs),
        .id_rt    (i_IF_ID_rt),
        .load_use (load_use)
    );

    assign step_pulse = i_step & ~i_step_q;
    assign o_halted   = (state == ST_HALTED);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            i_step_q  <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            i_step_q  <= i_step;
        end
    end

    // The accept cycle counts as the first of DRAIN_CYCLES enabled cycles,
    // so DRAIN freezes once the incremented count reaches DRAIN_CYCLES-1.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        o_PCwrite      = 1'b0;
        o_IF_ID_write  = 1'b0;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_bubble = 1'b0;

        if (i_reset || state == ST_HALTED)
            o_pipe_en = 1'b0;
        else if (i_debug_mode)
            o_pipe_en = step_pulse;
        else
            o_pipe_en = 1'b1;

        if (o_pipe_en) begin
            case (state)
                ST_RUN: begin
                    if (i_branch_taken) begin
                        o_PCwrite      = 1'b1;
                        o_IF_ID_write  = 1'b1;
                        o_IF_ID_flush  = 1'b1;
                        o_ID_EX_bubble = 1'b1;
                    end else if (load_use) begin
                        o_ID_EX_bubble = 1'b1;
                    end else if (i_halt) begin
                        state_next     = ST_DRAIN;
                        drain_cnt_next = '0;
                    end else begin
                        o_PCwrite      = 1'b1;
                        o_IF_ID_write  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    o_ID_EX_bubble = 1'b1;
                    drain_cnt_next = drain_cnt + DRAIN_W'(1);
                    if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 2))
                        state_next = ST_HALTED;
                end
                ST_HALTED: begin
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

`ifdef FLOW_CTRL_PERF_CNT_EN
    logic [NB_CNT-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (o_pipe_en && load_use && !i_branch_taken)
                stall_cnt <= stall_cnt + NB_CNT'(1);
            if (o_pipe_en && i_branch_taken)
                flush_cnt <= flush_cnt + NB_CNT'(1);
        end
    end

    assign o_stall_count = stall_cnt;
    assign o_flush_count = flush_cnt;
`else
    assign o_stall_count = '0;
    assign o_flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed self-checking bench for pipeline_flow_ctrl: stalls, flushes,
// debug stepping, halt draining and async reset. Counter checks follow FLOW_CTRL_PERF_CNT_EN.
module tb_pipeline_flow_ctrl;

    localparam int NB_REG_ADDR  = 5;
    localparam int DRAIN_CYCLES = 4;
    localparam int NB_CNT       = 32;

`ifdef FLOW_CTRL_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // Control vector order: {pipe_en, PCwrite, IF_ID_write, flush, bubble, halted}
    localparam logic [5:0] CTRL_IDLE   = 6'b000000;
    localparam logic [5:0] CTRL_RUN    = 6'b111000;
    localparam logic [5:0] CTRL_STALL  = 6'b100010;
    localparam logic [5:0] CTRL_FLUSH  = 6'b111110;
    localparam logic [5:0] CTRL_ACCEPT = 6'b100000;
    localparam logic [5:0] CTRL_DRAIN  = 6'b100010;
    localparam logic [5:0] CTRL_HALTED = 6'b000001;

    logic                   i_clk;
    logic                   i_reset;
    logic                   i_ID_EX_memRead;
    logic [NB_REG_ADDR-1:0] i_ID_EX_rt;
    logic [NB_REG_ADDR-1:0] i_IF_ID_rs;
    logic [NB_REG_ADDR-1:0] i_IF_ID_rt;
    logic                   i_branch_taken;
    logic                   i_halt;
    logic                   i_debug_mode;
    logic                   i_step;
    logic                   o_pipe_en;
    logic                   o_PCwrite;
    logic                   o_IF_ID_write;
    logic                   o_IF_ID_flush;
    logic                   o_ID_EX_bubble;
    logic                   o_halted;
    logic [NB_CNT-1:0]      o_stall_count;
    logic [NB_CNT-1:0]      o_flush_count;
    logic [5:0]             ctrl;

    int n_compared   = 0;
    int n_mismatched = 0;
    int exp_stall    = 0;
    int exp_flush    = 0;
    int enabled_cycles;

    pipeline_flow_ctrl #(
        .NB_REG_ADDR (NB_REG_ADDR),
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .NB_CNT      (NB_CNT)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_ID_EX_memRead(i_ID_EX_memRead),
        .i_ID_EX_rt     (i_ID_EX_rt),
        .i_IF_ID_rs     (i_IF_ID_rs),
        .i_IF_ID_rt     (i_IF_ID_rt),
        .i_branch_taken (i_branch_taken),
        .i_halt         (i_halt),
        .i_debug_mode   (i_debug_mode),
        .i_step         (i_step),
        .o_pipe_en      (o_pipe_en),
        .o_PCwrite      (o_PCwrite),
        .o_IF_ID_write  (o_IF_ID_write),
        .o_IF_ID_flush  (o_IF_ID_flush),
        .o_ID_EX_bubble (o_ID_EX_bubble),
        .o_halted       (o_halted),
        .o_stall_count  (o_stall_count),
        .o_flush_count  (o_flush_count)
    );

    assign ctrl = {o_pipe_en, o_PCwrite, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_bubble, o_halted};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_stall_cnt"}, o_stall_count, PERF_EN ? 32'(exp_stall) : 32'd0);
        checkOutput({tag, "_flush_cnt"}, o_flush_count, PERF_EN ? 32'(exp_flush) : 32'd0);
    endtask

    task automatic applyStimulus(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic br, input logic ht,
                                 input logic dbg, input logic stp);
        i_ID_EX_memRead = mr;
        i_ID_EX_rt      = ex_rt;
        i_IF_ID_rs      = rs;
        i_IF_ID_rt      = rt;
        i_branch_taken  = br;
        i_halt          = ht;
        i_debug_mode    = dbg;
        i_step          = stp;
    endtask

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
    endtask

    // One cycle: drive just after the edge, check controls at the falling edge.
    task automatic runVector(input string tag, input logic mr, input logic [4:0] ex_rt,
                             input logic [4:0] rs, input logic [4:0] rt, input logic br,
                             input logic ht, input logic dbg, input logic stp,
                             input logic [5:0] exp_ctrl);
        nextCycle();
        applyStimulus(mr, ex_rt, rs, rt, br, ht, dbg, stp);
        @(negedge i_clk);
        checkOutput(tag, 32'(ctrl), 32'(exp_ctrl));
    endtask

    initial begin
        i_reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("reset_ctrl", 32'(ctrl), 32'(CTRL_IDLE));
        checkCounters("reset");

        nextCycle();
        i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("run_after_reset", 32'(ctrl), 32'(CTRL_RUN));

        // Load-use detection on rs, on rt, and the register-0 / no-load exclusions
        runVector("lu_rs",      1, 5, 5, 0, 0, 0, 0, 0, CTRL_STALL);
        checkCounters("lu_rs");
        exp_stall = 1;
        runVector("lu_rt",      1, 7, 3, 7, 0, 0, 0, 0, CTRL_STALL);
        checkCounters("lu_rt");
        exp_stall = 2;
        runVector("lu_r0",      1, 0, 0, 0, 0, 0, 0, 0, CTRL_RUN);
        checkCounters("lu_r0");
        runVector("no_memread", 0, 5, 5, 5, 0, 0, 0, 0, CTRL_RUN);

        // Branch overrides load-use
        runVector("br_lu",      1, 5, 5, 0, 1, 0, 0, 0, CTRL_FLUSH);
        exp_flush = 1;
        runVector("after_br",   0, 0, 0, 0, 0, 0, 0, 0, CTRL_RUN);
        checkCounters("br_lu");

        // Halt rejected when it coincides with load-use or a taken branch
        runVector("halt_lu",    1, 5, 5, 0, 0, 1, 0, 0, CTRL_STALL);
        exp_stall = 3;
        runVector("halt_lu_rej", 0, 0, 0, 0, 0, 0, 0, 0, CTRL_RUN);
        checkCounters("halt_lu");
        runVector("halt_br",    0, 0, 0, 0, 1, 1, 0, 0, CTRL_FLUSH);
        exp_flush = 2;
        runVector("halt_br_rej", 0, 0, 0, 0, 0, 0, 0, 0, CTRL_RUN);
        checkCounters("halt_br");

        // Debug mode: frozen without a step edge, load-use not counted
        runVector("dbg_idle",   0, 0, 0, 0, 0, 0, 1, 0, CTRL_IDLE);
        runVector("dbg_lu",     1, 5, 5, 0, 0, 0, 1, 0, CTRL_IDLE);
        runVector("dbg_idle2",  0, 0, 0, 0, 0, 0, 1, 0, CTRL_IDLE);
        checkCounters("dbg_lu");

        for (int i = 0; i < 10; i++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
            @(negedge i_clk);
            checkOutput("step_hold", 32'(ctrl), (i == 0) ? 32'(CTRL_RUN) : 32'(CTRL_IDLE));
        end

        runVector("step_low",   0, 0, 0, 0, 0, 0, 1, 0, CTRL_IDLE);
        enabled_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 0, 1, (i % 2 == 0));
            @(negedge i_clk);
            if (o_pipe_en === 1'b1)
                enabled_cycles++;
        end
        checkOutput("step_edges", 32'(enabled_cycles), 32'd3);

        runVector("dbg_step_lu", 1, 5, 5, 0, 0, 0, 1, 1, CTRL_STALL);
        exp_stall = 4;
        runVector("dbg_after",  0, 0, 0, 0, 0, 0, 1, 0, CTRL_IDLE);
        checkCounters("dbg_step_lu");
        runVector("free_run",   0, 0, 0, 0, 0, 0, 0, 0, CTRL_RUN);

        // Halt acceptance, three drain cycles, then frozen
        runVector("halt_accept", 0, 0, 0, 0, 0, 1, 0, 0, CTRL_ACCEPT);
        runVector("drain_0",    0, 0, 0, 0, 0, 0, 0, 0, CTRL_DRAIN);
        runVector("drain_1",    0, 0, 0, 0, 0, 0, 0, 0, CTRL_DRAIN);
        runVector("drain_2",    0, 0, 0, 0, 0, 0, 0, 0, CTRL_DRAIN);
        runVector("halted",     0, 0, 0, 0, 0, 0, 0, 0, CTRL_HALTED);
        runVector("halted_br",  0, 0, 0, 0, 1, 0, 0, 0, CTRL_HALTED);
        runVector("halted_dbg", 0, 0, 0, 0, 0, 0, 1, 1, CTRL_HALTED);
        checkCounters("halted");

        // Asynchronous reset between edges while HALTED
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        i_reset = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        checkOutput("rst_in_halted", 32'(ctrl), 32'(CTRL_IDLE));
        checkCounters("rst_in_halted");
        nextCycle();
        i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("run_after_halt_rst", 32'(ctrl), 32'(CTRL_RUN));

        // Asynchronous reset in the middle of DRAIN
        runVector("halt_accept2", 0, 0, 0, 0, 0, 1, 0, 0, CTRL_ACCEPT);
        runVector("drain_a",    0, 0, 0, 0, 0, 0, 0, 0, CTRL_DRAIN);
        i_reset = 1'b1;
        #1;
        checkOutput("rst_in_drain", 32'(ctrl), 32'(CTRL_IDLE));
        nextCycle();
        i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("run_after_drain_rst", 32'(ctrl), 32'(CTRL_RUN));
        runVector("still_run",  0, 0, 0, 0, 0, 0, 0, 0, CTRL_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
